// File: rtl/riscv_pkg.sv
// Shared RV32I core constants: integer register width, register count and address width.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage : riscv_pkg

// File: rtl/riscv_regfile.sv
// RV32I integer register file: two combinational read ports, one synchronous write port,
// x0 hardwired to zero.
module riscv_regfile
    import riscv_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int NUM_REGS = riscv_pkg::NUM_REGS,
    parameter int ADDR_W   = REG_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              RegWEn_i,
    input  logic [ADDR_W-1:0] rsW_i,
    input  logic [DATA_W-1:0] dataW_i,
    input  logic [ADDR_W-1:0] rs1_i,
    input  logic [ADDR_W-1:0] rs2_i,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              write_en;

    // Entry 0 is cleared by reset and never written, so it folds away to a constant.
    assign write_en = RegWEn_i && (rsW_i != ZERO_ADDR);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[rsW_i] <= dataW_i;
        end
    end

    // No write bypass: a same-cycle write is visible only after the edge.
    assign data1_o = (rs1_i == ZERO_ADDR) ? '0 : regs[rs1_i];
    assign data2_o = (rs2_i == ZERO_ADDR) ? '0 : regs[rs2_i];

endmodule : riscv_regfile

// File: tb/tb_riscv_regfile.sv
// Directed self-checking bench for riscv_regfile with hand-computed expected values.
module tb_riscv_regfile;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWEn_i;
    logic [4:0]  rsW_i;
    logic [31:0] dataW_i;
    logic [4:0]  rs1_i;
    logic [4:0]  rs2_i;
    logic [31:0] data1_o;
    logic [31:0] data2_o;

    int n_chk  = 0;
    int n_pass = 0;

    riscv_regfile dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .RegWEn_i (RegWEn_i),
        .rsW_i    (rsW_i),
        .dataW_i  (dataW_i),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .data1_o  (data1_o),
        .data2_o  (data2_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are changed and outputs sampled away from it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i    = 1'b1;
        RegWEn_i = 1'b0;
        rsW_i    = 5'd0;
        dataW_i  = 32'h0;
        rs1_i    = 5'd5;
        rs2_i    = 5'd31;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("reset_x5", data1_o, 32'h0);
        check("reset_x31", data2_o, 32'h0);

        // write x5 then reset clears it
        RegWEn_i = 1'b1; rsW_i = 5'd5; dataW_i = 32'h13579bdf;
        tick();
        RegWEn_i = 1'b0;
        #1;
        check("x5_written", data1_o, 32'h13579bdf);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        rs1_i = 5'd5; rs2_i = 5'd5;
        #1;
        check("rst_clr_p1", data1_o, 32'h0);
        check("rst_clr_p2", data2_o, 32'h0);

        // basic write/read
        RegWEn_i = 1'b1; rsW_i = 5'd3; dataW_i = 32'h13579bdf;
        tick();
        rs1_i = 5'd3; rs2_i = 5'd4;
        rsW_i = 5'd4; dataW_i = 32'h00000001;
        #1;
        check("x3_read", data1_o, 32'h13579bdf);
        check("x4_no_bypass0", data2_o, 32'h0);
        tick();
        dataW_i = 32'hffff1357;
        #1;
        check("x4_first", data2_o, 32'h00000001);
        check("x4_no_bypass1", data2_o, 32'h00000001);
        tick();
        #1;
        check("x4_second", data2_o, 32'hffff1357);
        check("x3_stable", data1_o, 32'h13579bdf);

        // write enable low blocks writes
        RegWEn_i = 1'b0; rsW_i = 5'd3; dataW_i = 32'hffff1357;
        tick();
        tick();
        tick();
        check("we_low_x3", data1_o, 32'h13579bdf);
        RegWEn_i = 1'b1;
        tick();
        RegWEn_i = 1'b0;
        #1;
        check("we_high_p1", data1_o, 32'hffff1357);
        check("we_high_p2", data2_o, 32'hffff1357);

        // combinational read between edges
        RegWEn_i = 1'b1; rsW_i = 5'd8; dataW_i = 32'h00000246;
        tick();
        RegWEn_i = 1'b0;
        @(negedge clk_i);
        rs1_i = 5'd3;
        #1;
        check("comb_before", data1_o, 32'hffff1357);
        rs1_i = 5'd8;
        #1;
        check("comb_after", data1_o, 32'h00000246);

        // x0 hardwired
        RegWEn_i = 1'b1; rsW_i = 5'd0; dataW_i = 32'hdeadbeef;
        tick();
        RegWEn_i = 1'b0;
        rs1_i = 5'd0; rs2_i = 5'd8;
        #1;
        check("x0_zero", data1_o, 32'h0);
        check("x0_write_no_alias", data2_o, 32'h00000246);

        // reset wins over simultaneous write, write lands after release
        rst_i = 1'b1; RegWEn_i = 1'b1; rsW_i = 5'd12; dataW_i = 32'h1317131f;
        tick();
        rs1_i = 5'd12; rs2_i = 5'd8;
        #1;
        check("rst_prio_x12", data1_o, 32'h0);
        check("rst_prio_x8", data2_o, 32'h0);
        rst_i = 1'b0;
        #1;
        check("rst_rel_pre_edge", data1_o, 32'h0);
        tick();
        check("rst_rel_x12", data1_o, 32'h1317131f);

        // held enable rewrites each edge; both ports and rd on same register
        dataW_i = 32'haaaa5555;
        rs2_i = 5'd12;
        #1;
        check("hold_old", data2_o, 32'h1317131f);
        tick();
        check("hold_new_p1", data1_o, 32'haaaa5555);
        check("hold_new_p2", data2_o, 32'haaaa5555);
        RegWEn_i = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule : tb_riscv_regfile
